// File: rtl/absdiff_pkg.sv
// Shared encodings for the iterative absolute-difference unit: FSM state codes
// and datapath mux selects.
package absdiff_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    localparam logic SEL_LOAD = 1'b0;
    localparam logic SEL_CALC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        CALC = STATE_CALC,
        DONE = STATE_DONE
    } state_t;

endpackage

// File: rtl/absdiff_iter_dpath.sv
// Datapath for the iterative absolute-difference unit: A/B registers, operand
// muxes, comparator and subtractor; the control FSM drives the selects/enables.
module absdiff_iter_dpath
    import absdiff_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    input  logic             a_mux_sel,
    input  logic             b_mux_sel,
    input  logic             a_en,
    input  logic             b_en,
    output logic             a_lt_b,
    output logic [NBITS-1:0] result
);

    logic [NBITS-1:0] a_r;
    logic [NBITS-1:0] b_r;
    logic [NBITS-1:0] diff_s;
    logic [NBITS-1:0] calc_a_s;
    logic [NBITS-1:0] a_next_s;
    logic [NBITS-1:0] b_next_s;

    // Compare, subtract and steer either the swapped or the subtracted value into A.
    always_comb begin
        a_lt_b   = (a_r < b_r);
        diff_s   = a_r - b_r;
        calc_a_s = a_lt_b ? b_r : diff_s;
        if (a_mux_sel == SEL_CALC) begin
            a_next_s = calc_a_s;
        end else begin
            a_next_s = in_a;
        end
        if (b_mux_sel == SEL_CALC) begin
            b_next_s = a_r;
        end else begin
            b_next_s = in_b;
        end
    end

    // Operand registers with independent enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {NBITS{1'b0}};
            b_r <= {NBITS{1'b0}};
        end else begin
            if (a_en) begin
                a_r <= a_next_s;
            end
            if (b_en) begin
                b_r <= b_next_s;
            end
        end
    end

    assign result = a_r;

endmodule

// File: rtl/absdiff_iter_unit.sv
// Iterative |a - b| unit with val/rdy streams: control FSM around absdiff_iter_dpath.
// Define ABSDIFF_SWAP_FLAG_EN to add the ostream_swapped output (high when a < b).
module absdiff_iter_unit
    import absdiff_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] istream_msg_a,
    input  logic [NBITS-1:0] istream_msg_b,
    output logic             ostream_val,
    input  logic             ostream_rdy,
`ifdef ABSDIFF_SWAP_FLAG_EN
    output logic             ostream_swapped,
`endif
    output logic [NBITS-1:0] ostream_msg
);

    state_t state_r;
    logic   a_mux_sel;
    logic   b_mux_sel;
    logic   a_en;
    logic   b_en;
    logic   a_lt_b;

    absdiff_iter_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk       (clk),
        .rst       (rst),
        .in_a      (istream_msg_a),
        .in_b      (istream_msg_b),
        .a_mux_sel (a_mux_sel),
        .b_mux_sel (b_mux_sel),
        .a_en      (a_en),
        .b_en      (b_en),
        .a_lt_b    (a_lt_b),
        .result    (ostream_msg)
    );

    // Datapath control; B only moves on a load or a swap, never on the subtract step.
    always_comb begin
        a_mux_sel = SEL_LOAD;
        b_mux_sel = SEL_LOAD;
        a_en      = 1'b0;
        b_en      = 1'b0;
        case (state_r)
            IDLE: begin
                if (istream_val) begin
                    a_en = 1'b1;
                    b_en = 1'b1;
                end else begin
                    a_en = 1'b0;
                    b_en = 1'b0;
                end
            end
            CALC: begin
                a_mux_sel = SEL_CALC;
                b_mux_sel = SEL_CALC;
                a_en      = 1'b1;
                b_en      = a_lt_b;
            end
            default: begin
                a_en = 1'b0;
                b_en = 1'b0;
            end
        endcase
    end

    // Control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            istream_rdy <= 1'b1;
            ostream_val <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (istream_val) begin
                        state_r     <= CALC;
                        istream_rdy <= 1'b0;
                    end
                end
                CALC: begin
                    if (!a_lt_b) begin
                        state_r     <= DONE;
                        ostream_val <= 1'b1;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state_r     <= IDLE;
                        ostream_val <= 1'b0;
                        istream_rdy <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    istream_rdy <= 1'b1;
                    ostream_val <= 1'b0;
                end
            endcase
        end
    end

`ifdef ABSDIFF_SWAP_FLAG_EN
    // Swap flag: set on the CALC swap step, cleared once the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ostream_swapped <= 1'b0;
        end else if ((state_r == CALC) && a_lt_b) begin
            ostream_swapped <= 1'b1;
        end else if ((state_r == DONE) && ostream_rdy) begin
            ostream_swapped <= 1'b0;
        end
    end
`endif

endmodule
